dual_config_controller: RTL

DUAL_CONFIG_CONTROLLER -- requirements
Module: dual_config_controller

---
 rtl/dual_config_controller.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dual_config_controller.sv
// -----------------------------------------------------------------------------
// dual_config_controller
//
// Sequences accesses to a dual-configuration Avalon-MM slave on behalf of a
// simple valid/ready command interface. Three operations are supported:
//   00 reconfigure  : select image, poll the busy flag, then trigger
//   01 read status  : single read of the status register
//   10 watchdog     : write the watchdog-reset code to the trigger register
//   11 reserved     : no bus access, answered with an error
//
// Parameters
//   READ_LATENCY  cycles from an avmm_read pulse to valid avmm_readdata (1..7)
//   BUSY_TIMEOUT  number of busy polls allowed before giving up (16-bit)
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op, cmd_image_sel operation code and target image
//   resp_valid            one-cycle completion pulse
//   resp_err, resp_data   error flag and status word, valid with resp_valid
//   busy                  high whenever a command is in progress
//   avmm_*                Avalon-MM master towards the dual-config slave
// -----------------------------------------------------------------------------
module dual_config_controller #(
  parameter int READ_LATENCY = 2,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_image_sel,

  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_data,
  output logic        busy,

  output logic [2:0]  avmm_address,
  output logic        avmm_read,
  output logic        avmm_write,
  output logic [31:0] avmm_writedata,
  input  logic [31:0] avmm_readdata
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WR_SEL    = 3'd1;
  localparam logic [2:0] POLL_RD   = 3'd2;
  localparam logic [2:0] POLL_WAIT = 3'd3;
  localparam logic [2:0] WR_TRIG   = 3'd4;
  localparam logic [2:0] RD_STAT   = 3'd5;
  localparam logic [2:0] RD_WAIT   = 3'd6;
  localparam logic [2:0] RESP      = 3'd7;

  localparam logic [1:0] OP_RECONFIG = 2'b00;
  localparam logic [1:0] OP_STATUS   = 2'b01;
  localparam logic [1:0] OP_WATCHDOG = 2'b10;
  localparam logic [1:0] OP_RESERVED = 2'b11;

  localparam logic [2:0] ADDR_TRIGGER = 3'd0;
  localparam logic [2:0] ADDR_IMAGE   = 3'd1;
  localparam logic [2:0] ADDR_BUSY    = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;

  localparam logic [31:0] TRIG_RECONFIG = 32'h1;
  localparam logic [31:0] TRIG_WATCHDOG = 32'h2;

  localparam logic [2:0]  LAT_LAST = 3'(READ_LATENCY - 1);
  localparam logic [15:0] TIMEOUT  = 16'(BUSY_TIMEOUT);
  localparam logic [15:0] POLL_MAX = 16'hFFFF;

  logic [2:0]  state,    state_n;
  logic [2:0]  lat_cnt,  lat_n;
  logic [15:0] poll_cnt, poll_n;
  logic        err_q,    err_n;
  logic [31:0] data_q,   data_n;

  // Next values of the Avalon strobes. They are computed on the transition
  // INTO a state, so the registered pulse is high during that state's cycle.
  // This is what makes the read-data sample point line up exactly
  // READ_LATENCY cycles after the pulse.
  logic        rd_n, wr_n;
  logic [2:0]  addr_n;
  logic [31:0] wdata_n;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_n = state;
    lat_n   = lat_cnt;
    poll_n  = poll_cnt;
    err_n   = err_q;
    data_n  = data_q;
    rd_n    = 1'b0;
    wr_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          // The command is consumed here: its fields go straight into the
          // Avalon address/data registers for the first access.
          err_n  = 1'b0;
          data_n = '0;
          lat_n  = '0;
          case (cmd_op)
            OP_RECONFIG: begin
              state_n = WR_SEL;
              wr_n    = 1'b1;
              addr_n  = ADDR_IMAGE;
              wdata_n = {30'd0, cmd_image_sel, 1'b1};
            end
            OP_STATUS: begin
              state_n = RD_STAT;
              rd_n    = 1'b1;
              addr_n  = ADDR_STATUS;
            end
            OP_WATCHDOG: begin
              state_n = WR_TRIG;
              wr_n    = 1'b1;
              addr_n  = ADDR_TRIGGER;
              wdata_n = TRIG_WATCHDOG;
            end
            OP_RESERVED: begin
              state_n = RESP;
              err_n   = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end
      end

      WR_SEL: begin
        state_n = POLL_RD;
        rd_n    = 1'b1;
        addr_n  = ADDR_BUSY;
      end

      POLL_RD: begin
        state_n = POLL_WAIT;
        lat_n   = '0;
        if (poll_cnt != POLL_MAX) poll_n = poll_cnt + 16'd1;
      end

      POLL_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          if (!avmm_readdata[0]) begin
            state_n = WR_TRIG;
            wr_n    = 1'b1;
            addr_n  = ADDR_TRIGGER;
            wdata_n = TRIG_RECONFIG;
          end else if (poll_cnt >= TIMEOUT) begin
            state_n = RESP;
            err_n   = 1'b1;
          end else begin
            state_n = POLL_RD;
            rd_n    = 1'b1;
            addr_n  = ADDR_BUSY;
          end
        end else begin
          lat_n = lat_cnt + 3'd1;
        end
      end

      WR_TRIG: state_n = RESP;

      RD_STAT: begin
        state_n = RD_WAIT;
        lat_n   = '0;
      end

      RD_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          state_n = RESP;
          data_n  = avmm_readdata;
        end else begin
          lat_n = lat_cnt + 3'd1;
        end
      end

      RESP: begin
        state_n = IDLE;
        poll_n  = '0;
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      poll_cnt       <= '0;
      err_q          <= 1'b0;
      data_q         <= '0;
      avmm_read      <= 1'b0;
      avmm_write     <= 1'b0;
      avmm_address   <= '0;
      avmm_writedata <= '0;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_data      <= '0;
    end else begin
      state          <= state_n;
      lat_cnt        <= lat_n;
      poll_cnt       <= poll_n;
      err_q          <= err_n;
      data_q         <= data_n;
      avmm_read      <= rd_n;
      avmm_write     <= wr_n;
      avmm_address   <= addr_n;
      avmm_writedata <= wdata_n;
      // Response fields are only non-zero in the resp_valid cycle.
      resp_valid     <= (state == RESP);
      resp_err       <= (state == RESP) & err_q;
      resp_data      <= (state == RESP) ? data_q : '0;
    end
  end

endmodule
